// File: rtl/equiv_lock_detector.sv
// Lock/unlock hysteresis on a valid-qualified equivalence flag, with a
// saturating mismatch counter for status readout.
module equiv_lock_detector #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flag_valid,
    input  logic             equivalent,
    input  logic             clear,
    output logic             locked,
    output logic             lock_lost,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_total
);

    localparam int unsigned CTR_W = 8;
    localparam logic [CTR_W-1:0] LOCK_TGT   = CTR_W'(LOCK_CNT);
    localparam logic [CTR_W-1:0] UNLOCK_TGT = CTR_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] TOTAL_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_ACQUIRING = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CTR_W-1:0]   r_run;
    logic [CTR_W-1:0]   w_run_nxt;
    logic [CTR_W-1:0]   r_miss;
    logic [CTR_W-1:0]   w_miss_nxt;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   w_total_nxt;
    logic               r_locked;
    logic               w_locked_nxt;
    logic               r_lock_lost;
    logic               w_lock_lost_nxt;

    // State and counter registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= ST_UNLOCKED;
            r_run       <= '0;
            r_miss      <= '0;
            r_total     <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
            r_total     <= w_total_nxt;
            r_locked    <= w_locked_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    // Next-state and next-output logic; clear overrides any sample
    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_miss_nxt      = r_miss;
        w_total_nxt     = r_total;
        w_locked_nxt    = r_locked;
        w_lock_lost_nxt = 1'b0;

        if (clear) begin
            w_state_nxt  = ST_UNLOCKED;
            w_run_nxt    = '0;
            w_miss_nxt   = '0;
            w_total_nxt  = '0;
            w_locked_nxt = 1'b0;
        end else if (flag_valid) begin
            if (!equivalent && (r_total != TOTAL_MAX)) begin
                w_total_nxt = r_total + CNT_W'(1);
            end

            case (r_state)
                ST_UNLOCKED: begin
                    if (equivalent) begin
                        w_state_nxt = ST_ACQUIRING;
                        w_run_nxt   = CTR_W'(1);
                    end
                end
                ST_ACQUIRING: begin
                    if (!equivalent) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_run_nxt   = '0;
                    end else if ((r_run + CTR_W'(1)) == LOCK_TGT) begin
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                        w_run_nxt    = '0;
                    end else begin
                        w_run_nxt = r_run + CTR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!equivalent) begin
                        if (UNLOCK_TGT == CTR_W'(1)) begin
                            w_state_nxt     = ST_UNLOCKED;
                            w_locked_nxt    = 1'b0;
                            w_lock_lost_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_HOLDOFF;
                            w_miss_nxt  = CTR_W'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (equivalent) begin
                        w_state_nxt = ST_LOCKED;
                        w_miss_nxt  = '0;
                    end else if ((r_miss + CTR_W'(1)) == UNLOCK_TGT) begin
                        w_state_nxt     = ST_UNLOCKED;
                        w_locked_nxt    = 1'b0;
                        w_lock_lost_nxt = 1'b1;
                        w_miss_nxt      = '0;
                    end else begin
                        w_miss_nxt = r_miss + CTR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                end
            endcase
        end
    end

    assign locked         = r_locked;
    assign lock_lost      = r_lock_lost;
    assign state          = r_state;
    assign mismatch_total = r_total;

endmodule

// File: tb/tb_equiv_lock_detector.sv
// Randomized and directed checks of equiv_lock_detector against a
// run-length based reference model.
module tb_equiv_lock_detector;

    localparam int unsigned LOCK_CNT   = 4;
    localparam int unsigned UNLOCK_CNT = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int          SAT        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             flag_valid = 1'b0;
    logic             equivalent = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             lock_lost;
    logic [1:0]       state;
    logic [CNT_W-1:0] mismatch_total;

    int n_cmp = 0;
    int n_err = 0;

    // Model: lock flag plus lengths of the current hit and miss runs
    int m_locked;
    int m_lost;
    int m_run;
    int m_misses;
    int m_total;

    int acq_seq [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int acq_st  [8] = '{1, 1, 1, 0, 1, 1, 1, 2};
    int hys_seq [4] = '{0, 1, 0, 0};
    int hys_st  [4] = '{3, 2, 3, 0};
    int hys_lk  [4] = '{1, 1, 1, 0};
    int hys_ll  [4] = '{0, 0, 0, 1};

    equiv_lock_detector #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rstN          (rstN),
        .flag_valid    (flag_valid),
        .equivalent    (equivalent),
        .clear         (clear),
        .locked        (locked),
        .lock_lost     (lock_lost),
        .state         (state),
        .mismatch_total(mismatch_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_state();
        if (m_locked != 0) return (m_misses > 0) ? 3 : 2;
        return (m_run > 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_lost = 0; m_run = 0; m_misses = 0; m_total = 0;
    endtask

    task automatic model_step(input logic v, input logic e, input logic c);
        m_lost = 0;
        if (c) begin
            m_locked = 0; m_run = 0; m_misses = 0; m_total = 0;
        end else if (v) begin
            if (e) begin
                m_misses = 0;
                if (m_locked == 0) begin
                    m_run++;
                    if (m_run == int'(LOCK_CNT)) begin
                        m_locked = 1;
                        m_run    = 0;
                    end
                end
            end else begin
                if (m_total < SAT) m_total++;
                m_run = 0;
                if (m_locked != 0) begin
                    m_misses++;
                    if (m_misses == int'(UNLOCK_CNT)) begin
                        m_locked = 0;
                        m_lost   = 1;
                        m_misses = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  32'(state),          m_state());
        check({tag, ".locked"}, 32'(locked),         m_locked);
        check({tag, ".lost"},   32'(lock_lost),      m_lost);
        check({tag, ".total"},  32'(mismatch_total), m_total);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input logic v, input logic e, input logic c, input string tag);
        flag_valid = v; equivalent = e; clear = c;
        @(posedge clk);
        model_step(v, e, c);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Reset held for two edges with random inputs
        for (int i = 0; i < 2; i++) begin
            flag_valid = 1'($urandom); equivalent = 1'($urandom); clear = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        check("rst.state",  32'(state), 0);
        check("rst.locked", 32'(locked), 0);
        check("rst.lost",   32'(lock_lost), 0);
        check("rst.total",  32'(mismatch_total), 0);
        flag_valid = 1'b0; equivalent = 1'b0; clear = 1'b0;
        rstN = 1'b1;

        // Acquire with an interrupting miss
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'(acq_seq[i]), 1'b0, "acq");
            check("acq.state_tbl", 32'(state), acq_st[i]);
        end
        check("acq.locked_end", 32'(locked), 1);
        check("acq.total_end", 32'(mismatch_total), 1);

        // Hysteresis: miss, hit, miss, miss
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'(hys_seq[i]), 1'b0, "hys");
            check("hys.state_tbl",  32'(state), hys_st[i]);
            check("hys.locked_tbl", 32'(locked), hys_lk[i]);
            check("hys.lost_tbl",   32'(lock_lost), hys_ll[i]);
        end
        cycle(1'b0, 1'b0, 1'b0, "hys_idle");
        check("hys.lost_pulse_end", 32'(lock_lost), 0);
        check("hys.total_end", 32'(mismatch_total), 4);

        // Valid gating mid-acquisition
        cycle(1'b1, 1'b1, 1'b0, "gate");
        cycle(1'b1, 1'b1, 1'b0, "gate");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "gate_idle");
            check("gate.hold_state", 32'(state), 1);
        end
        cycle(1'b1, 1'b1, 1'b0, "gate");
        cycle(1'b1, 1'b1, 1'b0, "gate");
        check("gate.locked_state", 32'(state), 2);

        // Clear beats a simultaneous miss
        cycle(1'b1, 1'b0, 1'b1, "clr");
        check("clr.state",  32'(state), 0);
        check("clr.locked", 32'(locked), 0);
        check("clr.lost",   32'(lock_lost), 0);
        check("clr.total",  32'(mismatch_total), 0);

        // Saturation of mismatch_total
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, "sat");
            check("sat.total_tbl", 32'(mismatch_total), (i + 1 < SAT) ? i + 1 : SAT);
            check("sat.state_tbl", 32'(state), 0);
        end

        // Async reset mid-cycle while locked
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, "relock");
        check("arst.pre_locked", 32'(locked), 1);
        #2 rstN = 1'b0;
        #1;
        check("arst.state",  32'(state), 0);
        check("arst.locked", 32'(locked), 0);
        check("arst.lost",   32'(lock_lost), 0);
        check("arst.total",  32'(mismatch_total), 0);
        model_reset();
        @(negedge clk);
        rstN = 1'b1;

        // Randomized traffic biased toward hits so locks occur
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 63) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/equiv_lock_detector.md
# equiv_lock_detector

Downstream consumer of the per-cycle `equivalent` flag produced by `status_flag`. The block qualifies the flag with a valid strobe and runs a lock/unlock hysteresis state machine. It declares lock after `LOCK_CNT` consecutive equivalent samples and drops lock after `UNLOCK_CNT` consecutive non-equivalent samples. It also keeps a saturating total of mismatches for status readout.

## Interface

Parameters:

- `LOCK_CNT`, 4: consecutive valid equivalent samples required to lock; legal range 2..255.
- `UNLOCK_CNT`, 2: consecutive valid mismatching samples that drop lock; legal range 1..255.
- `CNT_W`, 16: width of `mismatch_total`.

Ports:

- `clk`, input, 1: clock; all state updates on posedge.
- `rstN`, input, 1: reset, asynchronous, active-low.
- `flag_valid`, input, 1: `equivalent` is sampled this cycle.
- `equivalent`, input, 1: registered equivalence flag from `status_flag`.
- `clear`, input, 1: synchronous soft clear.
- `locked`, output, 1: lock status.
- `lock_lost`, output, 1: one-cycle pulse on lock-to-unlock transition.
- `state`, output, 2: FSM state encoding: UNLOCKED=0, ACQUIRING=1, LOCKED=2, HOLDOFF=3.
- `mismatch_total`, output, `CNT_W`: saturating count of valid mismatches.

## Operation

- Sample event occurs when `flag_valid`=1. Sample types:
  - hit: `equivalent`=1.
  - miss: `equivalent`=0.
  - `flag_valid`=0: no state, counter or output change, except that `lock_lost` returns to 0.
- Internal counters are 8 bits: `run` counts hits, `miss` counts misses.
- FSM transitions:
  - UNLOCKED:
    - hit → ACQUIRING, `run`=1.
    - miss → stays UNLOCKED.
  - ACQUIRING:
    - hit with `run`+1 == `LOCK_CNT` → LOCKED, `locked`=1, `run`=0.
    - hit otherwise → `run`++.
    - miss → UNLOCKED, `run`=0.
  - LOCKED:
    - hit → stays LOCKED.
    - miss with `UNLOCK_CNT`==1 → UNLOCKED, `locked`=0, `lock_lost`=1.
    - miss otherwise → HOLDOFF, `miss`=1.
  - HOLDOFF (`locked` stays 1):
    - hit → LOCKED, `miss`=0.
    - miss with `miss`+1 == `UNLOCK_CNT` → UNLOCKED, `locked`=0, `lock_lost`=1, `miss`=0.
    - miss otherwise → `miss`++.
- `mismatch_total` increments on every miss in any state and saturates at 2^`CNT_W`−1. No wrap.
- `clear`=1 has priority over any simultaneous sample. Its effect:
  - state → UNLOCKED, `run`, `miss` and `mismatch_total` → 0, `locked`=0.
  - `lock_lost`=0, even if the block was locked (a clear is not a lock loss).
- Asynchronous reset mid-operation immediately forces all outputs and counters to their reset values, regardless of `clk`.

## Timing

- All outputs are registered. No combinational path from input to output.
- Reset values: `locked`=0, `lock_lost`=0, `state`=0 (UNLOCKED), `mismatch_total`=0.
- Latency: a sample at posedge k is reflected on outputs after posedge k.
  - With `flag_valid` held high and `equivalent`=1 from posedge 1, `locked` rises after posedge `LOCK_CNT`.
- `lock_lost` is high for exactly one cycle, the cycle in which `locked` first reads 0.
- Relock is legal immediately: a hit in the cycle after `lock_lost` enters ACQUIRING.
- Upstream `equivalent` is itself registered one cycle after its data. The integrator aligns `flag_valid` to the cycle the flag is valid. This block adds no realignment.

## Test plan

All scenarios use `LOCK_CNT`=4, `UNLOCK_CNT`=2, `CNT_W`=4.

- Reset: hold `rstN`=0 for 2 cycles with random inputs → all outputs 0, `state`=0. Assert `rstN`=0 asynchronously mid-cycle while LOCKED → outputs clear before the next edge.
- Acquire: 3 hits, 1 miss, then 4 hits with `flag_valid`=1 → `state` goes 1,1,1,0, then 1,1,1,2. `locked`=1 only after the 8th sample. `mismatch_total`=1.
- Hysteresis: while LOCKED, apply miss, hit, miss, miss →
  - `state` goes 3, 2, 3, 0.
  - `locked` stays 1 until after the last miss.
  - `lock_lost` pulses for exactly one cycle.
  - `mismatch_total` increases by 3.
- Valid gating: while ACQUIRING with `run`=2, drop `flag_valid` for 5 cycles with `equivalent`=0 → no change. Then 2 hits → LOCKED.
- Saturation: 20 valid misses → `mismatch_total` goes 1..15 and holds at 15. `state` stays 0.
- Clear priority: while LOCKED, assert `clear` together with a valid miss →
  - next cycle `state`=0, `locked`=0, `lock_lost`=0, `mismatch_total`=0.
  - the miss is not counted.
